// File: rtl/shared_mem_resp.sv
// Shared-memory responder: 2**ADDR_W x DATA_W array served to N_CORES load/store ports
// through a round-robin arbiter, one transaction at a time. Define SMEM_STATS_EN for ld/st counters.
//
// state   | meaning
// IDLE    | arbitrate; latch granted core and its address
// LD_ACC  | read memory into mem_dat, raise val_data for next cycle
// LD_RESP | load completion strobe visible
// ST_RESP | store completion strobe visible; core drives store data next cycle
// ST_WR   | sample store data, write memory
module shared_mem_resp #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [N_CORES-1:0]          mem_req_ld,
    input  logic [N_CORES-1:0]          mem_req_st,
    input  logic [N_CORES*ADDR_W-1:0]   addr_shared_memory,
    input  logic [N_CORES*DATA_W-1:0]   mem_dat_st,
    output logic [DATA_W-1:0]           mem_dat,
    output logic [N_CORES-1:0]          val_data,
    output logic                        busy
`ifdef SMEM_STATS_EN
    ,
    output logic [15:0]                 ld_count,
    output logic [15:0]                 st_count
`endif
);

    localparam int IDX_W = $clog2(N_CORES);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_ACC  = 3'd1,
        LD_RESP = 3'd2,
        ST_RESP = 3'd3,
        ST_WR   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       gnt_q, gnt_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      mem_dat_q, mem_dat_d;
    logic [N_CORES-1:0]     val_data_q, val_data_d;
    logic                   wr_en;

    logic [DATA_W-1:0]      mem [DEPTH];

    logic [N_CORES-1:0]     req;
    logic                   found;
    logic [IDX_W-1:0]       pick;
    logic [IDX_W-1:0]       pick_next;
    int                     idx;

    assign req = mem_req_ld | mem_req_st;

    // Scan starting at rr_ptr so the most recently served core has lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < N_CORES; i++) begin
            idx = (int'(rr_ptr_q) + i) % N_CORES;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
        pick_next = (pick == IDX_W'(N_CORES - 1)) ? '0 : pick + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        rr_ptr_d   = rr_ptr_q;
        mem_dat_d  = mem_dat_q;
        val_data_d = '0;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d    = pick;
                    addr_d   = addr_shared_memory[int'(pick)*ADDR_W +: ADDR_W];
                    rr_ptr_d = pick_next;
                    // A core holding both requests is served its load first.
                    if (mem_req_ld[pick]) begin
                        state_d = LD_ACC;
                    end else begin
                        state_d          = ST_RESP;
                        val_data_d[pick] = 1'b1;
                    end
                end
            end
            LD_ACC: begin
                mem_dat_d         = mem[addr_q];
                val_data_d[gnt_q] = 1'b1;
                state_d           = LD_RESP;
            end
            LD_RESP: state_d = IDLE;
            ST_RESP: state_d = ST_WR;
            ST_WR: begin
                wr_en   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            rr_ptr_q   <= '0;
            addr_q     <= '0;
            mem_dat_q  <= '0;
            val_data_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            addr_q     <= addr_d;
            mem_dat_q  <= mem_dat_d;
            val_data_q <= val_data_d;
        end
    end

    // Array is not reset; an async reset forces state_q to IDLE, so a pending write is dropped.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr_q] <= mem_dat_st[int'(gnt_q)*DATA_W +: DATA_W];
        end
    end

    assign mem_dat  = mem_dat_q;
    assign val_data = val_data_q;
    assign busy     = (state_q != IDLE);

`ifdef SMEM_STATS_EN
    logic [15:0] ld_count_q, ld_count_d;
    logic [15:0] st_count_q, st_count_d;

    always_comb begin
        ld_count_d = ld_count_q;
        st_count_d = st_count_q;
        if (state_q == LD_RESP && ld_count_q != 16'hFFFF) ld_count_d = ld_count_q + 16'd1;
        if (state_q == ST_WR && st_count_q != 16'hFFFF)   st_count_d = st_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ld_count_q <= '0;
            st_count_q <= '0;
        end else begin
            ld_count_q <= ld_count_d;
            st_count_q <= st_count_d;
        end
    end

    assign ld_count = ld_count_q;
    assign st_count = st_count_q;
`endif

endmodule

// File: tb/tb_shared_mem_resp.sv
// Bench for shared_mem_resp: directed vector table, multi-cycle corner sequences, and a
// randomized multi-core run checked against a transaction-level model. Honours SMEM_STATS_EN.
module tb_shared_mem_resp;
    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int R  = 3000;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      ld_i, st_i;
    logic [N*AW-1:0]   addr_i;
    logic [N*DW-1:0]   dat_i;
    logic [DW-1:0]     mem_dat;
    logic [N-1:0]      val_data;
    logic              busy;
`ifdef SMEM_STATS_EN
    logic [15:0]       ld_count, st_count;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shared_mem_resp #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .mem_req_ld         (ld_i),
        .mem_req_st         (st_i),
        .addr_shared_memory (addr_i),
        .mem_dat_st         (dat_i),
        .mem_dat            (mem_dat),
        .val_data           (val_data),
        .busy               (busy)
`ifdef SMEM_STATS_EN
        ,
        .ld_count           (ld_count),
        .st_count           (st_count)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ld_i    = '0;
        st_i    = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Single transaction from core k; returns edges from request to val_data, strobe and data.
    task automatic txn(input int k, input bit st, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int lat, output logic [DW-1:0] rd, output logic [N-1:0] vd);
        lat = -1;
        rd  = '0;
        vd  = '0;
        addr_i[k*AW +: AW] = a;
        if (st) st_i[k] = 1'b1;
        else    ld_i[k] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (val_data != '0) begin
                lat = i;
                vd  = val_data;
                rd  = mem_dat;
                break;
            end
        end
        ld_i[k] = 1'b0;
        st_i[k] = 1'b0;
        if (st) begin
            dat_i[k*DW +: DW] = ~d;
            tick();
            dat_i[k*DW +: DW] = d;
            tick();
            dat_i[k*DW +: DW] = ~d;
        end else begin
            tick();
        end
    endtask

    typedef struct {
        int             core;
        bit             st;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  dat;
        int             lat;
        logic [DW-1:0]  rdat;
    } vec_t;

    vec_t            tbl [8];
    int              lat;
    logic [DW-1:0]   rd;
    logic [N-1:0]    vd;

    // Random-phase model state
    logic [N-1:0]    exp_val  [0:R+3];
    bit              exp_ld   [0:R+3];
    logic [DW-1:0]   exp_dat  [0:R+3];
    bit              exp_kn   [0:R+3];
    bit              exp_busy [0:R+3];
    logic [DW-1:0]   mmem  [4096];
    bit              known [4096];
    logic [AW-1:0]   pool  [32];
    int              cst   [N];
    bit              c_st  [N];
    logic [DW-1:0]   dat_c [N];
    int              free_at, ptr, g;
    logic [AW-1:0]   a;
    logic [DW-1:0]   last_dat;
    bit              last_known;

    initial begin
        ld_i   = '0;
        st_i   = '0;
        addr_i = '0;
        dat_i  = '0;
        tbl[0] = '{0, 1'b1, 12'h0A5, 8'h3C, 1, 8'h00};
        tbl[1] = '{1, 1'b0, 12'h0A5, 8'h00, 2, 8'h3C};
        tbl[2] = '{3, 1'b1, 12'h000, 8'h5A, 1, 8'h00};
        tbl[3] = '{2, 1'b0, 12'h000, 8'h00, 2, 8'h5A};
        tbl[4] = '{1, 1'b1, 12'hFFF, 8'h81, 1, 8'h00};
        tbl[5] = '{0, 1'b0, 12'hFFF, 8'h00, 2, 8'h81};
        tbl[6] = '{2, 1'b1, 12'h0A5, 8'hC3, 1, 8'h00};
        tbl[7] = '{3, 1'b0, 12'h0A5, 8'h00, 2, 8'hC3};

        do_reset();
        chk("rst_val", val_data, 0);
        chk("rst_dat", mem_dat, 0);
        chk("rst_busy", busy, 0);

        for (int i = 0; i < 8; i++) begin
            txn(tbl[i].core, tbl[i].st, tbl[i].addr, tbl[i].dat, lat, rd, vd);
            chk("tbl_lat", lat, tbl[i].lat);
            chk("tbl_vd", vd, 1 << tbl[i].core);
            if (!tbl[i].st) chk("tbl_dat", rd, tbl[i].rdat);
        end

        // Simultaneous loads from all cores, twice: order 0..3 each time, 3 cycles apart.
        for (int b = 0; b < 2; b++) begin
            logic [DW-1:0] expd [4];
            int j;
            expd[0] = 8'hC3; expd[1] = 8'h5A; expd[2] = 8'h81; expd[3] = 8'hC3;
            addr_i[0*AW +: AW] = 12'h0A5;
            addr_i[1*AW +: AW] = 12'h000;
            addr_i[2*AW +: AW] = 12'hFFF;
            addr_i[3*AW +: AW] = 12'h0A5;
            ld_i = '1;
            j = 0;
            for (int i = 1; i <= 30 && j < 4; i++) begin
                tick();
                if (val_data != '0) begin
                    chk("burst_vd", val_data, 1 << j);
                    chk("burst_cyc", i, 2 + 3 * j);
                    chk("burst_dat", mem_dat, expd[j]);
                    ld_i = ld_i & ~val_data;
                    j++;
                end
            end
            chk("burst_cnt", j, 4);
            ld_i = '0;
            tick();
        end

        // Core 2 with both ld and st at 12'hFFF: load first, store on the next grant.
        begin
            int nval;
            nval = 0;
            addr_i[2*AW +: AW] = 12'hFFF;
            dat_i[2*DW +: DW]  = 8'h00;
            ld_i[2] = 1'b1;
            st_i[2] = 1'b1;
            for (int i = 1; i <= 15; i++) begin
                tick();
                if (val_data != '0) begin
                    nval++;
                    if (nval == 1) begin
                        chk("both_ld_cyc", i, 2);
                        chk("both_ld_vd", val_data, 4'b0100);
                        chk("both_ld_dat", mem_dat, 8'h81);
                        ld_i[2] = 1'b0;
                    end else begin
                        chk("both_st_cyc", i, 4);
                        chk("both_st_vd", val_data, 4'b0100);
                        st_i[2] = 1'b0;
                        tick();
                        dat_i[2*DW +: DW] = 8'h99;
                        tick();
                        dat_i[2*DW +: DW] = 8'h00;
                        break;
                    end
                end
            end
            ld_i[2] = 1'b0;
            st_i[2] = 1'b0;
            chk("both_nval", nval, 2);
            txn(0, 1'b0, 12'hFFF, 8'h00, lat, rd, vd);
            chk("both_rd_dat", rd, 8'h99);
        end

        // Address latched at grant: changed during LD_ACC, old location still returned.
        txn(0, 1'b1, 12'h010, 8'h11, lat, rd, vd);
        txn(1, 1'b1, 12'h020, 8'h22, lat, rd, vd);
        begin
            int got;
            got = -1;
            addr_i[3*AW +: AW] = 12'h010;
            ld_i[3] = 1'b1;
            tick();
            addr_i[3*AW +: AW] = 12'h020;
            for (int i = 2; i <= 10; i++) begin
                tick();
                if (val_data != '0) begin
                    got = i;
                    chk("addr_chg_vd", val_data, 4'b1000);
                    chk("addr_chg_dat", mem_dat, 8'h11);
                    break;
                end
            end
            ld_i[3] = 1'b0;
            chk("addr_chg_lat", got, 2);
            tick();
        end

        // Reset in ST_RESP: strobe cleared at once, store dropped.
        begin
            bit seen;
            seen = 1'b0;
            addr_i[0*AW +: AW] = 12'h0A5;
            dat_i[0*DW +: DW]  = 8'h77;
            st_i[0] = 1'b1;
            for (int i = 1; i <= 10 && !seen; i++) begin
                tick();
                if (val_data != '0) seen = 1'b1;
            end
            chk("rstmid_seen", seen, 1);
            reset_n = 1'b0;
            #1;
            chk("rstmid_val", val_data, 0);
            chk("rstmid_busy", busy, 0);
            chk("rstmid_dat", mem_dat, 0);
            tick();
            st_i[0] = 1'b0;
            tick();
            reset_n = 1'b1;
            tick();
            chk("rstmid_idle", busy, 0);
            txn(1, 1'b0, 12'h0A5, 8'h00, lat, rd, vd);
            chk("rstmid_keep", rd, 8'hC3);
        end

`ifdef SMEM_STATS_EN
        do_reset();
        chk("stat_rst_ld", ld_count, 0);
        for (int i = 0; i < 5; i++) txn(0, 1'b0, 12'h010, 8'h00, lat, rd, vd);
        for (int i = 0; i < 2; i++) txn(1, 1'b1, 12'h030, 8'(i), lat, rd, vd);
        chk("stat_ld", ld_count, 5);
        chk("stat_st", st_count, 2);
        do_reset();
        chk("stat_clr_ld", ld_count, 0);
        chk("stat_clr_st", st_count, 0);
`endif

        // Randomized multi-core run against a transaction-level model.
        for (int i = 0; i <= R + 3; i++) begin
            exp_val[i]  = '0;
            exp_ld[i]   = 1'b0;
            exp_dat[i]  = '0;
            exp_kn[i]   = 1'b0;
            exp_busy[i] = 1'b0;
        end
        for (int i = 0; i < 4096; i++) known[i] = 1'b0;
        for (int i = 0; i < 32; i++) pool[i] = 12'($urandom);
        pool[0] = 12'h000;
        pool[1] = 12'hFFF;
        for (int k = 0; k < N; k++) cst[k] = 0;
        do_reset();
        free_at    = 0;
        ptr        = 0;
        last_dat   = '0;
        last_known = 1'b1;
        for (int cyc = 1; cyc <= R; cyc++) begin
            tick();
            chk("rnd_val", val_data, exp_val[cyc]);
            chk("rnd_busy", busy, exp_busy[cyc]);
            if (exp_ld[cyc]) begin
                last_dat   = exp_dat[cyc];
                last_known = exp_kn[cyc];
            end
            if (last_known) chk("rnd_dat", mem_dat, last_dat);

            for (int k = 0; k < N; k++) begin
                dat_i[k*DW +: DW] = 8'($urandom);
                if (cst[k] == 3) begin
                    dat_i[k*DW +: DW] = dat_c[k];
                    cst[k] = 0;
                end else if (cst[k] == 2) begin
                    if (exp_val[cyc][k]) begin
                        ld_i[k] = 1'b0;
                        st_i[k] = 1'b0;
                        cst[k]  = c_st[k] ? 3 : 0;
                    end else begin
                        addr_i[k*AW +: AW] = 12'($urandom);
                    end
                end else if (cst[k] == 0 && $urandom_range(0, 3) == 0) begin
                    c_st[k]  = ($urandom_range(0, 2) == 0);
                    dat_c[k] = 8'($urandom);
                    addr_i[k*AW +: AW] = pool[$urandom_range(0, 31)];
                    ld_i[k] = !c_st[k];
                    st_i[k] = c_st[k];
                    cst[k]  = 1;
                end
            end

            if (cyc >= free_at && (ld_i | st_i) != '0) begin
                g = -1;
                for (int i = 0; i < N; i++)
                    if (g < 0 && (ld_i[(ptr + i) % N] || st_i[(ptr + i) % N])) g = (ptr + i) % N;
                ptr    = (g + 1) % N;
                a      = addr_i[g*AW +: AW];
                cst[g] = 2;
                if (ld_i[g]) begin
                    exp_val[cyc+2][g] = 1'b1;
                    exp_ld[cyc+2]     = 1'b1;
                    exp_dat[cyc+2]    = mmem[a];
                    exp_kn[cyc+2]     = known[a];
                end else begin
                    exp_val[cyc+1][g] = 1'b1;
                    mmem[a]  = dat_c[g];
                    known[a] = 1'b1;
                end
                exp_busy[cyc+1] = 1'b1;
                exp_busy[cyc+2] = 1'b1;
                free_at = cyc + 3;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
